// File: rtl/led_pattern_sched.sv
// LED pattern scheduler: cycles LEFT -> RIGHT -> FILL -> BLINK -> LEFT on a
// prescaled step strobe, with a jump request, a freeze input and step/loop pulses.
module led_pattern_sched #(
    parameter int unsigned DIV     = 25000000,
    parameter int unsigned BLINK_N = 4
) (
    input  logic       CLK,
    input  logic       rs,
    input  logic       hold,
    input  logic       sel_req,
    input  logic [1:0] sel_mode,
    output logic [7:0] led,
    output logic [1:0] mode,
    output logic       tick,
    output logic       cycle_done
);

    typedef enum logic [1:0] {
        ST_LEFT  = 2'd0,
        ST_RIGHT = 2'd1,
        ST_FILL  = 2'd2,
        ST_BLINK = 2'd3
    } state_t;

    localparam logic [31:0] PCNT_LAST  = 32'(DIV - 1);
    localparam logic [7:0]  BLINK_LAST = 8'(2 * BLINK_N - 1);

    state_t      r_state, w_state_nxt;
    logic [7:0]  r_led,   w_led_nxt;
    logic [7:0]  r_bcnt,  w_bcnt_nxt;
    logic [31:0] r_pcnt,  w_pcnt_nxt;
    logic        r_tick,  w_tick_nxt;
    logic        r_done,  w_done_nxt;
    logic        w_step;

    // Value shown on led when a mode is entered
    function automatic logic [7:0] entry_led(input state_t s);
        case (s)
            ST_LEFT:  entry_led = 8'h01;
            ST_RIGHT: entry_led = 8'h80;
            default:  entry_led = 8'h00;
        endcase
    endfunction

    // Step strobe: prescaler at terminal count and not frozen
    always_comb begin
        w_step = (r_pcnt == PCNT_LAST) && !hold;
    end

    // State, pattern and prescaler registers
    always_ff @(posedge CLK or negedge rs) begin
        if (!rs) begin
            r_state <= ST_LEFT;
            r_led   <= 8'h01;
            r_bcnt  <= '0;
            r_pcnt  <= '0;
            r_tick  <= 1'b0;
            r_done  <= 1'b0;
        end else begin
            r_state <= w_state_nxt;
            r_led   <= w_led_nxt;
            r_bcnt  <= w_bcnt_nxt;
            r_pcnt  <= w_pcnt_nxt;
            r_tick  <= w_tick_nxt;
            r_done  <= w_done_nxt;
        end
    end

    // Next-state logic; a jump request overrides a coincident step
    always_comb begin
        w_state_nxt = r_state;
        w_led_nxt   = r_led;
        w_bcnt_nxt  = r_bcnt;
        w_pcnt_nxt  = r_pcnt;
        w_tick_nxt  = w_step;
        w_done_nxt  = 1'b0;

        if (!hold) begin
            w_pcnt_nxt = w_step ? '0 : r_pcnt + 32'd1;
        end

        if (sel_req) begin
            w_state_nxt = state_t'(sel_mode);
            w_led_nxt   = entry_led(state_t'(sel_mode));
            w_bcnt_nxt  = '0;
            w_pcnt_nxt  = '0;
            w_tick_nxt  = 1'b0;
        end else if (w_step) begin
            case (r_state)
                ST_LEFT: begin
                    if (r_led == 8'h80) begin
                        w_state_nxt = ST_RIGHT;
                        w_led_nxt   = entry_led(ST_RIGHT);
                    end else begin
                        w_led_nxt = r_led << 1;
                    end
                end
                ST_RIGHT: begin
                    if (r_led == 8'h01) begin
                        w_state_nxt = ST_FILL;
                        w_led_nxt   = entry_led(ST_FILL);
                    end else begin
                        w_led_nxt = r_led >> 1;
                    end
                end
                ST_FILL: begin
                    if (r_led == 8'hFF) begin
                        w_state_nxt = ST_BLINK;
                        w_led_nxt   = entry_led(ST_BLINK);
                        w_bcnt_nxt  = '0;
                    end else begin
                        w_led_nxt = {r_led[6:0], 1'b1};
                    end
                end
                default: begin
                    if (r_bcnt == BLINK_LAST) begin
                        w_state_nxt = ST_LEFT;
                        w_led_nxt   = entry_led(ST_LEFT);
                        w_bcnt_nxt  = '0;
                        w_done_nxt  = 1'b1;
                    end else begin
                        w_led_nxt  = ~r_led;
                        w_bcnt_nxt = r_bcnt + 8'd1;
                    end
                end
            endcase
        end
    end

    assign led        = r_led;
    assign mode       = r_state;
    assign tick       = r_tick;
    assign cycle_done = r_done;

endmodule

// File: tb/tb_led_pattern_sched.sv
// Directed bench for led_pattern_sched with DIV=4, BLINK_N=4.
module tb_led_pattern_sched;

    logic       CLK = 1'b0;
    logic       rs;
    logic       hold;
    logic       sel_req;
    logic [1:0] sel_mode;
    logic [7:0] led;
    logic [1:0] mode;
    logic       tick;
    logic       cycle_done;

    int n_checks = 0;
    int n_errors = 0;

    // Expected led / mode after each of the 33 steps of a full loop
    logic [7:0] exp_led [0:32] = '{
        8'h02, 8'h04, 8'h08, 8'h10, 8'h20, 8'h40, 8'h80, 8'h80,
        8'h40, 8'h20, 8'h10, 8'h08, 8'h04, 8'h02, 8'h01, 8'h00,
        8'h01, 8'h03, 8'h07, 8'h0F, 8'h1F, 8'h3F, 8'h7F, 8'hFF,
        8'h00, 8'hFF, 8'h00, 8'hFF, 8'h00, 8'hFF, 8'h00, 8'hFF,
        8'h01
    };
    logic [1:0] exp_mode [0:32] = '{
        2'd0, 2'd0, 2'd0, 2'd0, 2'd0, 2'd0, 2'd0, 2'd1,
        2'd1, 2'd1, 2'd1, 2'd1, 2'd1, 2'd1, 2'd1, 2'd2,
        2'd2, 2'd2, 2'd2, 2'd2, 2'd2, 2'd2, 2'd2, 2'd2,
        2'd3, 2'd3, 2'd3, 2'd3, 2'd3, 2'd3, 2'd3, 2'd3,
        2'd0
    };

    led_pattern_sched #(
        .DIV     (4),
        .BLINK_N (4)
    ) dut (
        .CLK        (CLK),
        .rs         (rs),
        .hold       (hold),
        .sel_req    (sel_req),
        .sel_mode   (sel_mode),
        .led        (led),
        .mode       (mode),
        .tick       (tick),
        .cycle_done (cycle_done)
    );

    always #5 CLK = ~CLK;

    task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h, expected %0h", tag, obs, exp);
        end
    endtask

    // Advance n rising edges, landing 1 time unit after the last one
    task automatic step_clk(input int unsigned n);
        for (int unsigned i = 0; i < n; i++) begin
            @(posedge CLK);
            #1;
        end
    endtask

    task automatic check_out(input string tag, input logic [7:0] e_led, input logic [1:0] e_mode,
                             input logic e_tick, input logic e_done);
        check_val({tag, ".led"},  32'(led),        32'(e_led));
        check_val({tag, ".mode"}, 32'(mode),       32'(e_mode));
        check_val({tag, ".tick"}, 32'(tick),       32'(e_tick));
        check_val({tag, ".done"}, 32'(cycle_done), 32'(e_done));
    endtask

    // Three quiet cycles then a step cycle with the given result
    task automatic one_step(input string tag, input logic [7:0] pre_led, input logic [1:0] pre_mode,
                            input logic [7:0] e_led, input logic [1:0] e_mode, input logic e_done);
        for (int unsigned i = 0; i < 3; i++) begin
            step_clk(1);
            check_out({tag, ".wait"}, pre_led, pre_mode, 1'b0, 1'b0);
        end
        step_clk(1);
        check_out(tag, e_led, e_mode, 1'b1, e_done);
    endtask

    initial begin
        rs       = 1'b0;
        hold     = 1'b0;
        sel_req  = 1'b0;
        sel_mode = 2'd0;

        step_clk(3);
        check_out("reset", 8'h01, 2'd0, 1'b0, 1'b0);
        rs = 1'b1;

        // Full loop from reset release
        begin
            logic [7:0] p_led;
            logic [1:0] p_mode;
            p_led  = 8'h01;
            p_mode = 2'd0;
            for (int k = 0; k < 33; k++) begin
                one_step($sformatf("loop%0d", k), p_led, p_mode, exp_led[k], exp_mode[k], k == 32);
                p_led  = exp_led[k];
                p_mode = exp_mode[k];
            end
        end

        // Freeze at pcnt=2 for 10 cycles
        step_clk(2);
        hold = 1'b1;
        for (int i = 0; i < 10; i++) begin
            step_clk(1);
            check_out("hold", 8'h01, 2'd0, 1'b0, 1'b0);
        end
        hold = 1'b0;
        step_clk(1);
        check_out("hold_rel1", 8'h01, 2'd0, 1'b0, 1'b0);
        step_clk(1);
        check_out("hold_rel2", 8'h02, 2'd0, 1'b1, 1'b0);

        // Jump to BLINK coincident with a step in LEFT
        step_clk(3);
        sel_req  = 1'b1;
        sel_mode = 2'd3;
        step_clk(1);
        sel_req = 1'b0;
        check_out("jump_blink", 8'h00, 2'd3, 1'b0, 1'b0);
        one_step("blink_b1", 8'h00, 2'd3, 8'hFF, 2'd3, 1'b0);
        one_step("blink_b2", 8'hFF, 2'd3, 8'h00, 2'd3, 1'b0);
        one_step("blink_b3", 8'h00, 2'd3, 8'hFF, 2'd3, 1'b0);
        one_step("blink_b4", 8'hFF, 2'd3, 8'h00, 2'd3, 1'b0);
        one_step("blink_b5", 8'h00, 2'd3, 8'hFF, 2'd3, 1'b0);

        // Asynchronous reset mid-BLINK (bcnt=5)
        step_clk(2);
        rs = 1'b0;
        #2;
        check_out("async_rst", 8'h01, 2'd0, 1'b0, 1'b0);
        @(posedge CLK);
        #1;
        check_out("rst_held", 8'h01, 2'd0, 1'b0, 1'b0);
        rs = 1'b1;
        one_step("after_rst", 8'h01, 2'd0, 8'h02, 2'd0, 1'b0);

        // Jump to FILL while frozen
        hold     = 1'b1;
        sel_req  = 1'b1;
        sel_mode = 2'd2;
        step_clk(1);
        sel_req = 1'b0;
        check_out("hold_jump", 8'h00, 2'd2, 1'b0, 1'b0);
        for (int i = 0; i < 5; i++) begin
            step_clk(1);
            check_out("hold_jump_frz", 8'h00, 2'd2, 1'b0, 1'b0);
        end
        hold = 1'b0;
        one_step("hold_jump_rel", 8'h00, 2'd2, 8'h01, 2'd2, 1'b0);

        // Restart the current mode
        step_clk(1);
        sel_req  = 1'b1;
        sel_mode = 2'd2;
        step_clk(1);
        sel_req = 1'b0;
        check_out("same_mode", 8'h00, 2'd2, 1'b0, 1'b0);
        one_step("same_mode_step", 8'h00, 2'd2, 8'h01, 2'd2, 1'b0);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule

// File: doc/led_pattern_sched.md
LED_PATTERN_SCHED -- requirements
Module: led_pattern_sched

Interface
REQ-001 Parameter DIV, default 25000000, CLK cycles per pattern step; legal range 2..2^32-1.
REQ-002 Parameter BLINK_N, default 4, number of all-on phases in BLINK mode; legal range 1..127.
REQ-003 CLK  input  1  sole clock; all state changes on rising edge.
REQ-004 rs  input  1  reset, asynchronous, active-low.
REQ-005 hold  input  1  level; 1 freezes prescaler, pattern and counters.
REQ-006 sel_req  input  1  one-cycle request to jump to the mode given on sel_mode.
REQ-007 sel_mode  input  2  requested mode: 0 LEFT, 1 RIGHT, 2 FILL, 3 BLINK; sampled only when sel_req=1.
REQ-008 led  output  8  pattern drive, registered.
REQ-009 mode  output  2  current FSM state, same encoding as sel_mode, registered.
REQ-010 tick  output  1  registered one-cycle pulse, high in the cycle led first shows a stepped value.
REQ-011 cycle_done  output  1  registered one-cycle pulse on the BLINK->LEFT transition.

Function
REQ-012 Prescaler pcnt, 32 bit: when hold=0, DIV-1 -> 0, else +1; when hold=1, holds.
REQ-013 Internal step strobe step = (pcnt==DIV-1) && hold==0; led, mode and blink counter change only on step or sel_req.
REQ-014 Clock enable only; no derived or gated clock is generated.
REQ-015 Entry values: LEFT led=8'h01; RIGHT led=8'h80; FILL led=8'h00; BLINK led=8'h00 and bcnt=0.
REQ-016 LEFT, on step: led==8'h80 -> RIGHT with entry value; else led <= led<<1.
REQ-017 RIGHT, on step: led==8'h01 -> FILL with entry value; else led <= led>>1.
REQ-018 FILL, on step: led==8'hFF -> BLINK with entry value; else led <= {led[6:0],1'b1}.
REQ-019 BLINK, on step: bcnt==2*BLINK_N-1 -> LEFT with entry value, cycle_done=1; else led <= ~led, bcnt+1.
REQ-020 bcnt width 8 bit; never wraps at legal BLINK_N.
REQ-021 Full loop = 8+8+9+2*BLINK_N steps; with BLINK_N=4, 33 steps.
REQ-022 tick = registered step; cycle_done = registered (step && BLINK && bcnt==2*BLINK_N-1).
REQ-023 sel_req=1: next edge loads the entry values of sel_mode, sets mode=sel_mode, pcnt=0; tick and cycle_done stay 0 that cycle.
REQ-024 sel_req and step in the same cycle: sel_req wins; the step is discarded.
REQ-025 sel_req while hold=1: jump still applied; pattern then remains frozen until hold=0.
REQ-026 sel_mode equal to current mode: still restarts that mode at its entry value.
REQ-027 hold rising mid-count: pcnt keeps its value; on release, counting resumes from that value, no step lost or duplicated.

Reset
REQ-028 rs=0 asynchronously forces led=8'h01, mode=0, pcnt=0, bcnt=0, tick=0, cycle_done=0.
REQ-029 Reset mid-pattern or mid-BLINK discards all progress; no pending jump survives reset.
REQ-030 After rs release, first step occurs on the DIV-th rising edge with hold=0.

Verification (DIV=4, BLINK_N=4)
REQ-031 Release reset, hold=0 -> led 01,02,04,...,80 at 4-cycle spacing, then 80 with mode=1; tick high one cycle per step.
REQ-032 Run 33 steps (132 cycles) -> sequence LEFT/RIGHT/FILL (00,01,03,...,FF)/BLINK (00,FF x4), cycle_done once, led=01, mode=0.
REQ-033 hold=1 for 10 cycles at pcnt=2 -> led, mode and tick frozen; next step 2 cycles after release.
REQ-034 sel_req=1, sel_mode=3 coincident with a step in LEFT -> next cycle mode=3, led=00, tick=0, next step 4 cycles later gives FF.
REQ-035 rs=0 pulse during BLINK at bcnt=5 -> led=01, mode=0 immediately, no cycle_done; stepping resumes per REQ-030.
REQ-036 sel_req with sel_mode=2 while hold=1 -> mode=2, led=00 held; after release, led=01 after 4 cycles.
